vending_machine_multi: RTL and testbench

Parametrised multi-product successor to the single-price can vending machine. Accepts 1/5/10-unit coins into a saturating credit register, vends one of `N_PROD` products at per-product prices, returns change, and supports cancel/refund and coin rejection. Sits between the coin-acceptor/keypad front end and the dispenser/change-hopper drivers.

---
 rtl/vending_machine_multi_pkg.sv | 15 +
 rtl/vending_machine_multi_coin_decoder.sv | 27 ++
 rtl/vending_machine_multi.sv | 131 +++++++++++++
 tb/tb_vending_machine_multi.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/vending_machine_multi_pkg.sv
// Shared types and constants for the multi-product vending machine.
package vending_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        REFUND  = 2'd3
    } state_t;

    localparam int COIN_1  = 1;
    localparam int COIN_5  = 5;
    localparam int COIN_10 = 10;

endpackage

// File: rtl/vending_machine_multi_coin_decoder.sv
// Combinational coin strobe decoder: value of a single coin plus any/multi flags.
module coin_decoder
    import vending_pkg::*;
#(
    parameter int CREDIT_W = 8
) (
    input  logic                input10,
    input  logic                input50,
    input  logic                inputa0,
    output logic [CREDIT_W-1:0] value,
    output logic                coin_any,
    output logic                coin_multi
);

    // Decode the strobes; value is only meaningful when exactly one strobe is high
    always_comb begin
        coin_any   = input10 | input50 | inputa0;
        coin_multi = (input10 & input50) | (input10 & inputa0) | (input50 & inputa0);
        value      = '0;
        if (!coin_multi) begin
            if (input10) value = CREDIT_W'(COIN_1);
            if (input50) value = CREDIT_W'(COIN_5);
            if (inputa0) value = CREDIT_W'(COIN_10);
        end
    end

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-product vending machine: credit collection, per-product pricing,
// vend with change, cancel/refund and coin rejection. All outputs registered.
module vending_machine_multi
    import vending_pkg::*;
#(
    parameter int                           N_PROD     = 4,
    parameter int                           CREDIT_W   = 8,
    parameter int                           CREDIT_MAX = 99,
    parameter logic [N_PROD*CREDIT_W-1:0]   PRICES     = {8'd15, 8'd12, 8'd10, 8'd8},
    localparam int                          ID_W       = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                input10,
    input  logic                input50,
    input  logic                inputa0,
    input  logic                sel_valid,
    input  logic [ID_W-1:0]     sel_id,
    input  logic                cancel,
    output logic                can,
    output logic [ID_W-1:0]     can_id,
    output logic [CREDIT_W-1:0] chng,
    output logic                chng_valid,
    output logic                coin_rej,
    output logic                sel_nak,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    state_t                state;
    logic [CREDIT_W-1:0]   coin_value;
    logic                  coin_any;
    logic                  coin_multi;
    logic [CREDIT_W:0]     sum_wide;
    logic                  coin_over;
    logic [CREDIT_W-1:0]   price;
    logic                  id_ok;

    coin_decoder #(
        .CREDIT_W (CREDIT_W)
    ) u_coin_decoder (
        .input10    (input10),
        .input50    (input50),
        .inputa0    (inputa0),
        .value      (coin_value),
        .coin_any   (coin_any),
        .coin_multi (coin_multi)
    );

    // Price lookup for the selected product; out-of-range ids read as price 0 and are refused
    always_comb begin
        price = '0;
        id_ok = 1'b0;
        for (int i = 0; i < N_PROD; i++) begin
            if (int'(sel_id) == i) begin
                price = PRICES[i*CREDIT_W +: CREDIT_W];
                id_ok = 1'b1;
            end
        end
    end

    // Widened sum so an overflowing coin is caught before it wraps
    always_comb begin
        sum_wide  = {1'b0, credit} + {1'b0, coin_value};
        coin_over = (sum_wide > (CREDIT_W+1)'(CREDIT_MAX));
    end

    // Main FSM: pulses default low each cycle and are raised on the edge that takes the decision
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            credit     <= '0;
            can        <= 1'b0;
            can_id     <= '0;
            chng       <= '0;
            chng_valid <= 1'b0;
            coin_rej   <= 1'b0;
            sel_nak    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            can        <= 1'b0;
            can_id     <= '0;
            chng       <= '0;
            chng_valid <= 1'b0;
            coin_rej   <= 1'b0;
            sel_nak    <= 1'b0;
            busy       <= 1'b0;
            case (state)
                IDLE, COLLECT: begin
                    if (coin_any && (cancel || sel_valid || coin_multi || coin_over)) begin
                        coin_rej <= 1'b1;
                    end
                    if (cancel) begin
                        if (state == COLLECT) begin
                            state      <= REFUND;
                            chng       <= credit;
                            chng_valid <= 1'b1;
                            busy       <= 1'b1;
                        end
                    end else if (sel_valid) begin
                        if (state == COLLECT && id_ok && credit >= price) begin
                            state      <= VEND;
                            can        <= 1'b1;
                            can_id     <= sel_id;
                            chng       <= credit - price;
                            chng_valid <= 1'b1;
                            busy       <= 1'b1;
                        end else begin
                            sel_nak <= 1'b1;
                        end
                    end else if (coin_any && !coin_multi && !coin_over) begin
                        credit <= sum_wide[CREDIT_W-1:0];
                        state  <= COLLECT;
                    end
                end
                VEND, REFUND: begin
                    credit <= '0;
                    state  <= IDLE;
                    if (coin_any) begin
                        coin_rej <= 1'b1;
                    end
                end
                default: begin
                    credit <= '0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vending_machine_multi.sv
// Directed bench for vending_machine_multi with a queue of expected output records.
module tb_vending_machine_multi;

    localparam int N_PROD   = 4;
    localparam int CREDIT_W = 8;
    // Product 0..3 cost 15, 12, 10, 8 units (product i at bits [i*8 +: 8])
    localparam logic [31:0] BENCH_PRICES = {8'd8, 8'd10, 8'd12, 8'd15};

    logic                clk = 1'b0;
    logic                rst;
    logic                input10, input50, inputa0;
    logic                sel_valid;
    logic [1:0]          sel_id;
    logic                cancel;
    logic                can;
    logic [1:0]          can_id;
    logic [CREDIT_W-1:0] chng;
    logic                chng_valid;
    logic                coin_rej;
    logic                sel_nak;
    logic [CREDIT_W-1:0] credit;
    logic                busy;

    typedef struct {
        string      tag;
        logic       can;
        logic [1:0] can_id;
        logic [7:0] chng;
        logic       chng_valid;
        logic       coin_rej;
        logic       sel_nak;
        logic [7:0] credit;
        logic       busy;
    } exp_t;

    exp_t expQ[$];
    int   passCount  = 0;
    int   failCount  = 0;
    int   totalCount = 0;

    vending_machine_multi #(
        .N_PROD     (N_PROD),
        .CREDIT_W   (CREDIT_W),
        .CREDIT_MAX (99),
        .PRICES     (BENCH_PRICES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .input10    (input10),
        .input50    (input50),
        .inputa0    (inputa0),
        .sel_valid  (sel_valid),
        .sel_id     (sel_id),
        .cancel     (cancel),
        .can        (can),
        .can_id     (can_id),
        .chng       (chng),
        .chng_valid (chng_valid),
        .coin_rej   (coin_rej),
        .sel_nak    (sel_nak),
        .credit     (credit),
        .busy       (busy)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    function automatic exp_t mk(string tag, logic c, logic [1:0] cid, logic [7:0] ch,
                                logic cv, logic rej, logic nak, logic [7:0] cr, logic b);
        exp_t e;
        e.tag = tag; e.can = c; e.can_id = cid; e.chng = ch; e.chng_valid = cv;
        e.coin_rej = rej; e.sel_nak = nak; e.credit = cr; e.busy = b;
        return e;
    endfunction

    task automatic checkField(input string tag, input string field,
                              input logic [31:0] obs, input logic [31:0] expv);
        totalCount++;
        assert (obs === expv) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s.%s observed %0h expected %0h", tag, field, obs, expv);
        end
    endtask

    // Pop the oldest expectation and compare every output against it
    task automatic checkOutput();
        exp_t e;
        if (expQ.size() == 0) begin
            totalCount++;
            failCount++;
            $error("[TB] FAIL scoreboard observed empty queue expected an entry");
            return;
        end
        e = expQ.pop_front();
        checkField(e.tag, "can",        32'(can),        32'(e.can));
        checkField(e.tag, "can_id",     32'(can_id),     32'(e.can_id));
        checkField(e.tag, "chng",       32'(chng),       32'(e.chng));
        checkField(e.tag, "chng_valid", 32'(chng_valid), 32'(e.chng_valid));
        checkField(e.tag, "coin_rej",   32'(coin_rej),   32'(e.coin_rej));
        checkField(e.tag, "sel_nak",    32'(sel_nak),    32'(e.sel_nak));
        checkField(e.tag, "credit",     32'(credit),     32'(e.credit));
        checkField(e.tag, "busy",       32'(busy),       32'(e.busy));
    endtask

    // Drive one cycle of inputs (coins = {inputa0,input50,input10}), record the expected result, check it after the edge
    task automatic applyStimulus(input logic r, input logic [2:0] coins, input logic sv,
                                 input logic [1:0] id, input logic cn, input exp_t e);
        rst       = r;
        input10   = coins[0];
        input50   = coins[1];
        inputa0   = coins[2];
        sel_valid = sv;
        sel_id    = id;
        cancel    = cn;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        rst = 1'b0; input10 = 1'b0; input50 = 1'b0; inputa0 = 1'b0;
        sel_valid = 1'b0; sel_id = 2'd0; cancel = 1'b0;
        checkOutput();
    endtask

    localparam logic [2:0] C0  = 3'b000;
    localparam logic [2:0] C1  = 3'b001;
    localparam logic [2:0] C5  = 3'b010;
    localparam logic [2:0] C10 = 3'b100;

    initial begin
        rst = 1'b1; input10 = 1'b0; input50 = 1'b0; inputa0 = 1'b0;
        sel_valid = 1'b0; sel_id = 2'd0; cancel = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(1, C0, 0, 0, 0, mk("reset",      0, 0, 0, 0, 0, 0, 0, 0));
        applyStimulus(0, C0, 0, 0, 0, mk("idle",       0, 0, 0, 0, 0, 0, 0, 0));

        applyStimulus(0, C10, 0, 0, 0, mk("coin10",    0, 0, 0, 0, 0, 0, 10, 0));
        applyStimulus(0, C5,  0, 0, 0, mk("coin5",     0, 0, 0, 0, 0, 0, 15, 0));
        applyStimulus(0, C0,  1, 1, 0, mk("vend1",     1, 1, 3, 1, 0, 0, 15, 1));
        applyStimulus(0, C0,  0, 0, 0, mk("postvend1", 0, 0, 0, 0, 0, 0, 0, 0));

        applyStimulus(0, C10, 0, 0, 0, mk("credit10",  0, 0, 0, 0, 0, 0, 10, 0));
        applyStimulus(0, C0,  1, 0, 0, mk("nak_low",   0, 0, 0, 0, 0, 1, 10, 0));
        applyStimulus(0, C0,  0, 0, 1, mk("refund10",  0, 0, 10, 1, 0, 0, 10, 1));
        applyStimulus(0, C0,  0, 0, 0, mk("postrefund",0, 0, 0, 0, 0, 0, 0, 0));

        for (int i = 1; i <= 9; i++) begin
            applyStimulus(0, C10, 0, 0, 0, mk("build", 0, 0, 0, 0, 0, 0, 8'(10*i), 0));
        end
        applyStimulus(0, C5,  0, 0, 0, mk("credit95",  0, 0, 0, 0, 0, 0, 95, 0));
        applyStimulus(0, C10, 0, 0, 0, mk("over_rej",  0, 0, 0, 0, 1, 0, 95, 0));
        applyStimulus(0, C1,  0, 0, 0, mk("credit96",  0, 0, 0, 0, 0, 0, 96, 0));
        applyStimulus(0, C1|C5, 0, 0, 0, mk("multi_rej", 0, 0, 0, 0, 1, 0, 96, 0));
        applyStimulus(0, C1,  0, 0, 0, mk("credit97",  0, 0, 0, 0, 0, 0, 97, 0));
        applyStimulus(0, C1,  0, 0, 0, mk("credit98",  0, 0, 0, 0, 0, 0, 98, 0));
        applyStimulus(0, C1,  0, 0, 0, mk("credit99",  0, 0, 0, 0, 0, 0, 99, 0));
        applyStimulus(0, C1,  0, 0, 0, mk("max_rej",   0, 0, 0, 0, 1, 0, 99, 0));
        applyStimulus(0, C0,  0, 0, 1, mk("refund99",  0, 0, 99, 1, 0, 0, 99, 1));
        applyStimulus(0, C0,  0, 0, 0, mk("post99",    0, 0, 0, 0, 0, 0, 0, 0));

        applyStimulus(0, C5,  0, 0, 0, mk("credit5",   0, 0, 0, 0, 0, 0, 5, 0));
        applyStimulus(0, C1,  0, 0, 0, mk("credit6",   0, 0, 0, 0, 0, 0, 6, 0));
        applyStimulus(0, C1,  0, 0, 0, mk("credit7",   0, 0, 0, 0, 0, 0, 7, 0));
        applyStimulus(0, C1,  0, 0, 0, mk("credit8",   0, 0, 0, 0, 0, 0, 8, 0));
        applyStimulus(0, C0,  1, 3, 0, mk("vend_exact",1, 3, 0, 1, 0, 0, 8, 1));
        applyStimulus(0, C1,  0, 0, 0, mk("busy_rej",  0, 0, 0, 0, 1, 0, 0, 0));

        applyStimulus(0, C0,  1, 2, 0, mk("idle_nak",  0, 0, 0, 0, 0, 1, 0, 0));
        applyStimulus(0, C0,  0, 0, 1, mk("idle_cancel",0, 0, 0, 0, 0, 0, 0, 0));
        applyStimulus(0, C10, 0, 0, 0, mk("credit10b", 0, 0, 0, 0, 0, 0, 10, 0));
        applyStimulus(0, C10, 1, 0, 0, mk("sel_coin",  0, 0, 0, 0, 1, 1, 10, 0));
        applyStimulus(0, C5,  0, 0, 1, mk("cancel_coin",0, 0, 10, 1, 1, 0, 10, 1));
        applyStimulus(0, C0,  0, 0, 0, mk("postcancel",0, 0, 0, 0, 0, 0, 0, 0));

        applyStimulus(0, C10, 0, 0, 0, mk("credit10c", 0, 0, 0, 0, 0, 0, 10, 0));
        applyStimulus(0, C0,  1, 2, 0, mk("vend2",     1, 2, 0, 1, 0, 0, 10, 1));
        applyStimulus(1, C0,  0, 0, 0, mk("rst_vend",  0, 0, 0, 0, 0, 0, 0, 0));
        applyStimulus(0, C0,  0, 0, 0, mk("post_rst",  0, 0, 0, 0, 0, 0, 0, 0));

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
